if_stage: RTL and testbench

Fetch-side pipeline stage of the five-stage RV32I core: owns the program counter and the IF/ID pipeline register, and is the consumer of the load-use stall request produced by the hazard detector. It presents the registered rs1/rs2 fields that the hazard detector compares, holds PC and IF/ID on stall, and redirects and squashes on a taken branch or jump. It also drives the ID/EX bubble request and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/if_stage.sv | 71 +++++++
 tb/tb_if_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage of the RV32I pipeline: program counter, IF/ID register,
// load-use stall / branch-flush handling and a saturating stall-cycle counter.
module if_stage #(
  parameter int               WIDTH    = 32,
  parameter int               INDEX    = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] target_in,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic [31:0]      imem_data_in,
  output logic [WIDTH-1:0] ifid_pc_out,
  output logic [31:0]      ifid_instr_out,
  output logic             ifid_valid_out,
  output logic [INDEX-1:0] ifid_rs1_out,
  output logic [INDEX-1:0] ifid_rs2_out,
  output logic             idex_bubble_out,
  output logic [CNT_W-1:0] stall_count_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] ifid_pc;
  logic [31:0]      ifid_instr;
  logic             ifid_valid;
  logic [CNT_W-1:0] stall_cnt;

  // Flush outranks stall: a redirect must win even while a load-use stall is pending.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP;
      ifid_valid <= 1'b0;
    end else if (flush_in) begin
      pc         <= target_in;
      ifid_pc    <= '0;
      ifid_instr <= NOP;
      ifid_valid <= 1'b0;
    end else if (!stall_in) begin
      pc         <= pc + WIDTH'(4);
      ifid_pc    <= pc;
      ifid_instr <= imem_data_in;
      ifid_valid <= 1'b1;
    end
  end

  // Counts only stalls that actually freeze the pipe, saturating at all-ones.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_cnt <= '0;
    end else if (stall_in && !flush_in && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign imem_addr_out   = pc;
  assign ifid_pc_out     = ifid_pc;
  assign ifid_instr_out  = ifid_instr;
  assign ifid_valid_out  = ifid_valid;
  assign ifid_rs1_out    = ifid_instr[15 +: INDEX];
  assign ifid_rs2_out    = ifid_instr[20 +: INDEX];
  assign idex_bubble_out = stall_in | flush_in;
  assign stall_count_out = stall_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (RESET_PC 0x100/CNT_W 16 and RESET_PC 0xFFFFFFFC/CNT_W 2)
// share stimulus and are compared against a per-instance behavioural model.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] target;

  logic [31:0] addr_a, data_a, ipc_a, instr_a;
  logic        valid_a, bubble_a;
  logic [4:0]  rs1_a, rs2_a;
  logic [15:0] cnt_a;

  logic [31:0] addr_b, data_b, ipc_b, instr_b;
  logic        valid_b, bubble_b;
  logic [4:0]  rs1_b, rs2_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = dut_a, 1 = dut_b
  logic [31:0] m_pc [2];
  logic [31:0] m_ipc [2];
  logic [31:0] m_instr [2];
  logic        m_valid [2];
  int          m_cnt [2];
  int          m_cnt_max [2];
  logic [31:0] m_rst_pc [2];

  if_stage #(.WIDTH(32), .INDEX(5), .RESET_PC(32'h0000_0100), .CNT_W(16)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .stall_in(stall), .flush_in(flush),
    .target_in(target), .imem_addr_out(addr_a), .imem_data_in(data_a),
    .ifid_pc_out(ipc_a), .ifid_instr_out(instr_a), .ifid_valid_out(valid_a),
    .ifid_rs1_out(rs1_a), .ifid_rs2_out(rs2_a), .idex_bubble_out(bubble_a),
    .stall_count_out(cnt_a)
  );

  if_stage #(.WIDTH(32), .INDEX(5), .RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .stall_in(stall), .flush_in(flush),
    .target_in(target), .imem_addr_out(addr_b), .imem_data_in(data_b),
    .ifid_pc_out(ipc_b), .ifid_instr_out(instr_b), .ifid_valid_out(valid_b),
    .ifid_rs1_out(rs1_b), .ifid_rs2_out(rs2_b), .idex_bubble_out(bubble_b),
    .stall_count_out(cnt_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: imem_word = 32'h00A0_0093;
      32'h0000_0104: imem_word = 32'h0010_0113;
      32'h0000_0108: imem_word = 32'h0020_81B3;
      default:       imem_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  assign data_a = imem_word(addr_a);
  assign data_b = imem_word(addr_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]    = m_rst_pc[i];
      m_ipc[i]   = 32'h0;
      m_instr[i] = 32'h0000_0013;
      m_valid[i] = 1'b0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic check_state(input int i);
    string p;
    logic [31:0] o_addr, o_ipc, o_instr, o_valid, o_rs1, o_rs2, o_cnt;
    p       = (i == 0) ? "a" : "b";
    o_addr  = (i == 0) ? addr_a : addr_b;
    o_ipc   = (i == 0) ? ipc_a : ipc_b;
    o_instr = (i == 0) ? instr_a : instr_b;
    o_valid = (i == 0) ? {31'b0, valid_a} : {31'b0, valid_b};
    o_rs1   = (i == 0) ? {27'b0, rs1_a} : {27'b0, rs1_b};
    o_rs2   = (i == 0) ? {27'b0, rs2_a} : {27'b0, rs2_b};
    o_cnt   = (i == 0) ? {16'b0, cnt_a} : {30'b0, cnt_b};
    check({p, ".imem_addr"},  o_addr,  m_pc[i]);
    check({p, ".ifid_pc"},    o_ipc,   m_ipc[i]);
    check({p, ".ifid_instr"}, o_instr, m_instr[i]);
    check({p, ".ifid_valid"}, o_valid, {31'b0, m_valid[i]});
    check({p, ".rs1"},        o_rs1,   {27'b0, m_instr[i][19:15]});
    check({p, ".rs2"},        o_rs2,   {27'b0, m_instr[i][24:20]});
    check({p, ".stall_cnt"},  o_cnt,   32'(m_cnt[i]));
  endtask

  task automatic check_bubble(input logic exp);
    check("a.bubble", {31'b0, bubble_a}, {31'b0, exp});
    check("b.bubble", {31'b0, bubble_b}, {31'b0, exp});
  endtask

  // Driver: apply inputs for one cycle, then check the state after the edge
  task automatic step(input logic s, input logic f, input logic [31:0] t);
    logic [31:0] n_pc [2];
    logic [31:0] n_ipc [2];
    logic [31:0] n_instr [2];
    logic        n_valid [2];
    int          n_cnt [2];
    stall = s; flush = f; target = t;
    #1;
    check_bubble(s | f);
    check("a.imem_addr_pre", addr_a, m_pc[0]);
    check("b.imem_addr_pre", addr_b, m_pc[1]);
    for (int i = 0; i < 2; i++) begin
      n_pc[i] = m_pc[i]; n_ipc[i] = m_ipc[i]; n_instr[i] = m_instr[i];
      n_valid[i] = m_valid[i]; n_cnt[i] = m_cnt[i];
      if (f) begin
        n_pc[i] = t; n_ipc[i] = 32'h0; n_instr[i] = 32'h0000_0013; n_valid[i] = 1'b0;
      end else if (s) begin
        n_cnt[i] = (m_cnt[i] < m_cnt_max[i]) ? m_cnt[i] + 1 : m_cnt_max[i];
      end else begin
        n_ipc[i] = m_pc[i]; n_instr[i] = imem_word(m_pc[i]); n_valid[i] = 1'b1;
        n_pc[i] = m_pc[i] + 32'd4;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = n_pc[i]; m_ipc[i] = n_ipc[i]; m_instr[i] = n_instr[i];
      m_valid[i] = n_valid[i]; m_cnt[i] = n_cnt[i];
    end
    #1;
    check_state(0);
    check_state(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_rst_pc[0] = 32'h0000_0100; m_rst_pc[1] = 32'hFFFF_FFFC;
    m_cnt_max[0] = 65535;        m_cnt_max[1] = 3;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; target = 32'h0;
    model_reset();

    // Reset values, and bubble tracking inputs even under reset
    repeat (2) @(posedge clk);
    #1;
    check_state(0);
    check_state(1);
    check("a.reset_pc", addr_a, 32'h0000_0100);
    stall = 1'b1; #1; check_bubble(1'b1);
    stall = 1'b0; flush = 1'b1; #1; check_bubble(1'b1);
    flush = 1'b0; #1; check_bubble(1'b0);
    rst_n = 1'b1;

    // Free run: three fetches from 0x100; dut_b wraps past 0xFFFFFFFC
    step(0, 0, 0);
    check("b.wrap_pc", addr_b, 32'h0);
    check("b.wrap_ifid_pc", ipc_b, 32'hFFFF_FFFC);
    step(0, 0, 0);
    step(0, 0, 0);
    check("a.ifid_pc_108", ipc_a, 32'h0000_0108);
    check("a.ifid_instr_3", instr_a, 32'h0020_81B3);
    check("a.pc_10c", addr_a, 32'h0000_010C);

    // Two-cycle stall, then resume
    step(1, 0, 0);
    step(1, 0, 0);
    check("a.stall2_cnt", {16'b0, cnt_a}, 32'd2);
    check("a.stall2_pc", addr_a, 32'h0000_010C);
    step(0, 0, 0);
    check("a.resume_ifid_pc", ipc_a, 32'h0000_010C);

    // Flush to 0x200, then target fetched
    step(0, 1, 32'h0000_0200);
    check("a.flush_pc", addr_a, 32'h0000_0200);
    check("a.flush_instr", instr_a, 32'h0000_0013);
    step(0, 0, 0);
    check("a.flush_ifid_pc", ipc_a, 32'h0000_0200);

    // Stall and flush together: flush wins, no count
    step(1, 1, 32'h0000_0040);
    check("a.both_pc", addr_a, 32'h0000_0040);
    check("a.both_cnt", {16'b0, cnt_a}, 32'd2);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, $urandom & 32'hFFFF_FFFC);
    end

    // Fresh reset, then 5-cycle stall on the 2-bit counter
    rst_n = 1'b0; #1; model_reset();
    check_state(0); check_state(1);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0);
      check("b.sat_cnt", {30'b0, cnt_b}, (k < 3) ? 32'(k + 1) : 32'd3);
    end

    // Advance a little, stall, then reset between edges
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    rst_n = 1'b0; #1; model_reset();
    check("a.midrst_pc", addr_a, 32'h0000_0100);
    check("a.midrst_cnt", {16'b0, cnt_a}, 32'd0);
    check("b.midrst_cnt", {30'b0, cnt_b}, 32'd0);
    check_state(0); check_state(1);
    stall = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 0);
    check("a.post_rst_ifid_pc", ipc_a, 32'h0000_0100);
    check("b.post_rst_ifid_pc", ipc_b, 32'hFFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
